// File: rtl/sobel_window_3x3_pkg.sv
// sobel_window_3x3_pkg
//   Shared image-geometry defaults for the Sobel window producer, the edge
//   detector and the display timing. No ports; constants only.
package sobel_window_3x3_pkg;

  localparam int SOBEL_H_ACTIVE = 640;  // active pixels per line
  localparam int SOBEL_V_ACTIVE = 480;  // active lines per frame
  localparam int SOBEL_PIX_W    = 8;    // luma width
  localparam int SOBEL_X_W      = 10;   // column counter / center_x width
  localparam int SOBEL_Y_W      = 9;    // row counter / center_y width

  // Taps in the 3x3 window, z0..z8 row-major (z0 top-left, z8 bottom-right).
  localparam int SOBEL_TAPS     = 9;

endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer
//   One line of pixel storage: single address port, read-before-write,
//   registered read data.
// Ports:
//   clk      clock
//   we       access strobe; read and write both happen only when high
//   addr     column index
//   din      word written at addr
//   rd_word  unregistered old word at addr (same cycle as the access)
//   dout     old word at addr, registered on the accessing edge; holds otherwise
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rd_word,
  output logic [WIDTH-1:0] dout
);

  // Contents are never cleared; consumers mask stale data themselves.
  logic [WIDTH-1:0] r_mem [DEPTH];

  // The second line buffer of a chain is loaded with this buffer's old word
  // on the same edge, so the pre-write word is exposed before the register.
  assign rd_word = r_mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      dout         <= r_mem[addr];
      r_mem[addr]  <= din;
    end
  end

endmodule

// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3
//   Builds a sliding 3x3 luma window from a raster pixel stream for the Sobel
//   edge detector. Two line buffers hold lines y-1 and y-2; a 3x3 register
//   array shifts left one column per accepted pixel.
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   pixel_in/pixel_valid  raster pixel and its qualifier
//   sof                   first pixel of frame (with pixel_valid)
//   z0..z8                window taps, row-major, z8 = newest pixel
//   window_valid          one-cycle pulse per complete interior window
//   center_x/center_y     coordinates of z4
module sobel_window_3x3
  import sobel_window_3x3_pkg::*;
#(
  parameter int H_ACTIVE = SOBEL_H_ACTIVE,
  parameter int V_ACTIVE = SOBEL_V_ACTIVE,
  parameter int PIX_W    = SOBEL_PIX_W,
  parameter int X_W      = SOBEL_X_W,
  parameter int Y_W      = SOBEL_Y_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             pixel_valid,
  input  logic             sof,
  output logic [PIX_W-1:0] z0,
  output logic [PIX_W-1:0] z1,
  output logic [PIX_W-1:0] z2,
  output logic [PIX_W-1:0] z3,
  output logic [PIX_W-1:0] z4,
  output logic [PIX_W-1:0] z5,
  output logic [PIX_W-1:0] z6,
  output logic [PIX_W-1:0] z7,
  output logic [PIX_W-1:0] z8,
  output logic             window_valid,
  output logic [X_W-1:0]   center_x,
  output logic [Y_W-1:0]   center_y
);

  localparam int             AW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);
  localparam logic [X_W-1:0] X_TWO  = X_W'(2);
  localparam logic [Y_W-1:0] Y_TWO  = Y_W'(2);

  // ---------------------------------------------------------------- S0
  logic             w_acc;
  logic [X_W-1:0]   w_x_cur;
  logic [Y_W-1:0]   w_y_cur;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;

  // Reset dominates so nothing is written into the line buffers while held.
  assign w_acc   = pixel_valid & ~reset;
  // sof re-anchors this very pixel to (0,0), overriding any pending wrap.
  assign w_x_cur = sof ? '0 : r_x;
  assign w_y_cur = sof ? '0 : r_y;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_acc) begin
      if (w_x_cur == X_LAST) begin
        r_x <= '0;
        r_y <= (w_y_cur == Y_LAST) ? '0 : w_y_cur + 1'b1;
      end else begin
        r_x <= w_x_cur + 1'b1;
        r_y <= w_y_cur;
      end
    end
  end

  // lb_a holds line y-1; on each access its old word moves down into lb_b,
  // which therefore holds line y-2 at the same column.
  logic [PIX_W-1:0] w_lb_a_old, w_lb_a_q, w_lb_b_q, w_lb_b_old_unused;

  sobel_line_buffer #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W), .AW(AW)) u_lb_a (
    .clk     (clock),
    .we      (w_acc),
    .addr    (w_x_cur[AW-1:0]),
    .din     (pixel_in),
    .rd_word (w_lb_a_old),
    .dout    (w_lb_a_q)
  );

  // Nothing sits below lb_b, so its bypass word has no consumer.
  sobel_line_buffer #(.DEPTH(H_ACTIVE), .WIDTH(PIX_W), .AW(AW)) u_lb_b (
    .clk     (clock),
    .we      (w_acc),
    .addr    (w_x_cur[AW-1:0]),
    .din     (w_lb_a_old),
    .rd_word (w_lb_b_old_unused),
    .dout    (w_lb_b_q)
  );

  // ---------------------------------------------------------------- S1
  logic             r_v1;
  logic [PIX_W-1:0] r_pix1;
  logic [X_W-1:0]   r_x1;
  logic [Y_W-1:0]   r_y1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_pix1 <= '0;
      r_x1   <= '0;
      r_y1   <= '0;
    end else begin
      r_v1 <= w_acc;
      if (w_acc) begin
        r_pix1 <= pixel_in;
        r_x1   <= w_x_cur;
        r_y1   <= w_y_cur;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  // Window complete only once two full columns and two full lines of the
  // current frame are behind the newest pixel; this also hides stale RAM data
  // after reset or an early sof.
  logic                                w_interior;
  logic [2:0][PIX_W-1:0]               w_col;
  logic [SOBEL_TAPS-1:0][PIX_W-1:0]    r_z;
  logic                                r_wv;
  logic [X_W-1:0]                      r_cx;
  logic [Y_W-1:0]                      r_cy;

  assign w_interior = r_v1 && (r_x1 >= X_TWO) && (r_y1 >= Y_TWO);
  // Incoming right-hand column, top to bottom.
  assign w_col[0]   = w_lb_b_q;
  assign w_col[1]   = w_lb_a_q;
  assign w_col[2]   = r_pix1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_z  <= '0;
      r_wv <= 1'b0;
      r_cx <= '0;
      r_cy <= '0;
    end else begin
      r_wv <= w_interior;
      if (r_v1) begin
        for (int r = 0; r < 3; r++) begin
          r_z[3*r]     <= r_z[3*r+1];
          r_z[3*r + 1] <= r_z[3*r+2];
          r_z[3*r + 2] <= w_col[r];
        end
      end
      if (w_interior) begin
        r_cx <= r_x1 - 1'b1;
        r_cy <= r_y1 - 1'b1;
      end
    end
  end

  assign z0           = r_z[0];
  assign z1           = r_z[1];
  assign z2           = r_z[2];
  assign z3           = r_z[3];
  assign z4           = r_z[4];
  assign z5           = r_z[5];
  assign z6           = r_z[6];
  assign z7           = r_z[7];
  assign z8           = r_z[8];
  assign window_valid = r_wv;
  assign center_x     = r_cx;
  assign center_y     = r_cy;

endmodule
